// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its skid buffer.
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } fetchState_e;

   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
   localparam logic [31:0] INSTR_BYTES   = 32'd4;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } skidEntry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched instruction that decode could not take.
module fetch_skid_buf
   import fetch_stage_pkg::*;
(
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       load_i,
   input  logic       clear_i,
   input  skidEntry_t data_i,
   output skidEntry_t data_o,
   output logic       valid_o
);

   skidEntry_t data_q, data_d;
   logic       valid_q, valid_d;

   // Clear wins over load so a flush can never leave a stale entry behind.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         data_d  = data_i;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with one request in flight, a one-entry skid buffer and the IF/ID register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        Clk,
   input  logic        Rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   output logic [31:0] IFID_Instr,
   output logic [31:0] IFID_PCPlus4,
   output logic        IFID_Valid
);

   fetchState_e state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pendPc_q, pendPc_d;
   logic [31:0] ifidInstr_q, ifidInstr_d;
   logic [31:0] ifidPcPlus4_q, ifidPcPlus4_d;
   logic        ifidValid_q, ifidValid_d;
   logic        run_q;

   logic        rspArrive, ifidAdvance, fire;
   logic        skidLoad, skidClear, skidValid;
   skidEntry_t  skidIn, skidOut;

   assign rspArrive   = (state_q == ST_WAIT) && imem_rvalid;
   assign ifidAdvance = !Stall || !ifidValid_q;
   assign skidLoad    = rspArrive && !ifidAdvance && !Redirect;
   assign skidClear   = Redirect || (!Stall && skidValid);
   assign skidIn      = '{instr: imem_rdata, pc: pendPc_q};

   // run_q keeps the request low while reset is held and for the release cycle.
   assign imem_req  = run_q && !Redirect && !skidValid &&
                      ((state_q == ST_IDLE) || (rspArrive && ifidAdvance));
   assign imem_addr = pc_q;
   assign fire      = imem_req && imem_ack;

   fetch_skid_buf u_skid (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .load_i  (skidLoad),
      .clear_i (skidClear),
      .data_i  (skidIn),
      .data_o  (skidOut),
      .valid_o (skidValid)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      pendPc_d = pendPc_q;

      if (fire) begin
         pendPc_d = pc_q;
         pc_d     = pc_q + INSTR_BYTES;
      end

      if (Redirect) begin
         pc_d = {RedirectPC[31:2], 2'b00};
         unique case (state_q)
            ST_WAIT:  state_d = imem_rvalid ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: state_d = imem_rvalid ? ST_IDLE : ST_DRAIN;
            default:  state_d = ST_IDLE;
         endcase
      end else begin
         unique case (state_q)
            ST_IDLE:  state_d = fire ? ST_WAIT : ST_IDLE;
            ST_WAIT:  state_d = (imem_rvalid && !fire) ? ST_IDLE : ST_WAIT;
            ST_DRAIN: state_d = imem_rvalid ? ST_IDLE : ST_DRAIN;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // The skid entry always predates any arriving response, so it drains first.
   always_comb begin
      ifidInstr_d   = ifidInstr_q;
      ifidPcPlus4_d = ifidPcPlus4_q;
      ifidValid_d   = ifidValid_q;
      if (Redirect) begin
         ifidInstr_d = NOP_INSTR;
         ifidValid_d = 1'b0;
      end else if (ifidAdvance) begin
         if (skidValid) begin
            ifidInstr_d   = skidOut.instr;
            ifidPcPlus4_d = skidOut.pc + INSTR_BYTES;
            ifidValid_d   = 1'b1;
         end else if (rspArrive) begin
            ifidInstr_d   = imem_rdata;
            ifidPcPlus4_d = pendPc_q + INSTR_BYTES;
            ifidValid_d   = 1'b1;
         end else begin
            ifidInstr_d = NOP_INSTR;
            ifidValid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         pendPc_q      <= '0;
         ifidInstr_q   <= NOP_INSTR;
         ifidPcPlus4_q <= '0;
         ifidValid_q   <= 1'b0;
         run_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pendPc_q      <= pendPc_d;
         ifidInstr_q   <= ifidInstr_d;
         ifidPcPlus4_q <= ifidPcPlus4_d;
         ifidValid_q   <= ifidValid_d;
         run_q         <= 1'b1;
      end
   end

   assign IFID_Instr   = ifidInstr_q;
   assign IFID_PCPlus4 = ifidPcPlus4_q;
   assign IFID_Valid   = ifidValid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, cycle-by-cycle bench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        Stall;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic [31:0] IFID_Instr;
   logic [31:0] IFID_PCPlus4;
   logic        IFID_Valid;

   int checkCount = 0;
   int errorCount = 0;

   localparam logic [31:0] NOP = 32'h0000_0000;

   fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .Stall        (Stall),
      .Redirect     (Redirect),
      .RedirectPC   (RedirectPC),
      .IFID_Instr   (IFID_Instr),
      .IFID_PCPlus4 (IFID_PCPlus4),
      .IFID_Valid   (IFID_Valid)
   );

   always #5 Clk = ~Clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Drive one cycle's inputs and let combinational outputs settle.
   task automatic applyStimulus(input logic ack, input logic rvalid, input logic [31:0] rdata,
                                input logic stall, input logic redir, input logic [31:0] rpc);
      imem_ack    = ack;
      imem_rvalid = rvalid;
      imem_rdata  = rdata;
      Stall       = stall;
      Redirect    = redir;
      RedirectPC  = rpc;
      #1;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic checkIfid(input string tag, input logic valid, input logic [31:0] instr, input logic [31:0] pcp4);
      checkOutput({tag, "_valid"}, {31'd0, IFID_Valid}, {31'd0, valid});
      checkOutput({tag, "_instr"}, IFID_Instr, instr);
      checkOutput({tag, "_pcp4"}, IFID_PCPlus4, pcp4);
   endtask

   task automatic checkReq(input string tag, input logic req, input logic [31:0] addr);
      checkOutput({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
      if (req) checkOutput({tag, "_addr"}, imem_addr, addr);
   endtask

   initial begin
      Rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      tick();
      checkReq("rst_hold", 1'b0, 32'h0);
      checkIfid("rst_hold", 1'b0, NOP, 32'h0);

      // Release, then issue one request and reset while it is in flight.
      Rst_n = 1'b1;
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkReq("first_req", 1'b1, 32'h0);
      tick();
      Rst_n = 1'b0;
      #1;
      checkReq("rst_in_wait", 1'b0, 32'h0);
      checkIfid("rst_in_wait", 1'b0, NOP, 32'h0);
      tick();
      Rst_n = 1'b1;
      tick();
      applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
      checkReq("post_rst", 1'b1, 32'h0);
      tick();
      checkIfid("stale_rvalid", 1'b0, NOP, 32'h0);

      // Zero-wait stream A, B, C.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkReq("s_a", 1'b1, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 32'h0);
      checkReq("s_b", 1'b1, 32'h4);
      tick();
      checkIfid("s_A", 1'b1, 32'hAAAA_0001, 32'h4);
      applyStimulus(1'b1, 1'b1, 32'hBBBB_0002, 1'b0, 1'b0, 32'h0);
      checkReq("s_c", 1'b1, 32'h8);
      tick();
      checkIfid("s_B", 1'b1, 32'hBBBB_0002, 32'h8);
      applyStimulus(1'b0, 1'b1, 32'hCCCC_0003, 1'b0, 1'b0, 32'h0);
      tick();
      checkIfid("s_C", 1'b1, 32'hCCCC_0003, 32'hC);

      // Stall while B returns: B parks in the skid.
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
      checkReq("st_redir", 1'b0, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkReq("st_a", 1'b1, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b1, 32'h1111_0000, 1'b0, 1'b0, 32'h0);
      tick();
      checkIfid("st_A", 1'b1, 32'h1111_0000, 32'h4);
      applyStimulus(1'b1, 1'b1, 32'h2222_0000, 1'b1, 1'b0, 32'h0);
      checkReq("st_1", 1'b0, 32'h0);
      tick();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
         checkReq("st_hold", 1'b0, 32'h0);
         tick();
         checkIfid("st_hold", 1'b1, 32'h1111_0000, 32'h4);
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkReq("st_release", 1'b0, 32'h0);
      tick();
      checkIfid("st_B", 1'b1, 32'h2222_0000, 32'h8);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkReq("st_resume", 1'b1, 32'h8);
      tick();
      applyStimulus(1'b0, 1'b1, 32'h3333_0000, 1'b0, 1'b0, 32'h0);
      tick();
      checkIfid("st_C", 1'b1, 32'h3333_0000, 32'hC);

      // Redirect in WAIT without rvalid: drain the stale response.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkReq("rw_req", 1'b1, 32'hC);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
      checkReq("rw_redir", 1'b0, 32'h0);
      tick();
      checkIfid("rw_flush", 1'b0, NOP, 32'hC);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkReq("rw_drain", 1'b0, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
      checkReq("rw_drain_rv", 1'b0, 32'h0);
      tick();
      checkIfid("rw_drop", 1'b0, NOP, 32'hC);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkReq("rw_new", 1'b1, 32'h40);
      tick();
      applyStimulus(1'b0, 1'b1, 32'h4444_0000, 1'b0, 1'b0, 32'h0);
      tick();
      checkIfid("rw_D", 1'b1, 32'h4444_0000, 32'h44);

      // Redirect, Stall and rvalid together: redirect wins.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkReq("rs_req", 1'b1, 32'h44);
      tick();
      applyStimulus(1'b1, 1'b1, 32'h5555_0000, 1'b1, 1'b1, 32'h103);
      checkReq("rs_redir", 1'b0, 32'h0);
      tick();
      checkIfid("rs_flush", 1'b0, NOP, 32'h44);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkReq("rs_new", 1'b1, 32'h100);
      tick();
      applyStimulus(1'b0, 1'b1, 32'h6666_0000, 1'b0, 1'b0, 32'h0);
      tick();
      checkIfid("rs_F", 1'b1, 32'h6666_0000, 32'h104);

      // Address wrap at the top of the address space.
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkReq("wr_top", 1'b1, 32'hFFFF_FFFC);
      tick();
      applyStimulus(1'b1, 1'b1, 32'h7777_0000, 1'b0, 1'b0, 32'h0);
      checkReq("wr_zero", 1'b1, 32'h0);
      tick();
      checkIfid("wr_G", 1'b1, 32'h7777_0000, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h8888_0000, 1'b0, 1'b0, 32'h0);
      tick();
      checkIfid("wr_H", 1'b1, 32'h8888_0000, 32'h4);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
